// File: rtl/clk_div_pkg.sv
// Shared types and ratio helpers for the synchronous clock divider.
// Ratio N = 2^(sel+1); selects are clamped to the counter width.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SWITCH = 2'd2
    } state_t;

    localparam int CNT_W_DEF = 16;
    localparam int SEL_W_DEF = 4;

    function automatic int unsigned clamp_sel(
        input int unsigned sel,
        input int unsigned cnt_w
    );
        return (sel >= cnt_w) ? cnt_w - 1 : sel;
    endfunction

    function automatic logic [31:0] ratio_m1(input int unsigned sel);
        return (32'd2 << sel) - 32'd1;
    endfunction

endpackage

// File: rtl/clk_div_counter.sv
// Period counter with registered tick and square-wave outputs.
// Output flops load next-state values so they line up with the count.
module clk_div_counter
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [SEL_W-1:0] i_sel,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tick,
    output logic             o_clk_out
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic             r_clk_out;
    logic [CNT_W-1:0] w_m1;
    logic [CNT_W-1:0] w_half;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_m1      = CNT_W'(ratio_m1(32'(i_sel)));
    assign w_half    = CNT_W'(1) << i_sel;
    assign w_cnt_nxt = (r_cnt == w_m1) ? '0 : r_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_tick    <= 1'b0;
            r_clk_out <= 1'b0;
        end else if (i_clr) begin
            r_cnt     <= '0;
            r_tick    <= 1'b0;
            r_clk_out <= 1'b0;
        end else if (i_en) begin
            r_cnt     <= w_cnt_nxt;
            r_tick    <= (w_cnt_nxt == w_m1);
            r_clk_out <= |(w_cnt_nxt & w_half);
        end
    end

    assign o_cnt     = r_cnt;
    assign o_tick    = r_tick;
    assign o_clk_out = r_clk_out;

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time selectable clock divider with a valid/ready config port.
// Ratio changes and stops are deferred to the end of the current period.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SEL_W       = SEL_W_DEF,
    parameter int DEFAULT_SEL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [SEL_W-1:0] cfg_sel,
    input  logic             cfg_run,
    output logic             tick,
    output logic             clk_out,
    output logic             busy,
    output logic [SEL_W-1:0] cur_sel
);

    localparam logic [SEL_W-1:0] RST_SEL =
        SEL_W'(clamp_sel(DEFAULT_SEL, CNT_W));

    state_t           r_state;
    logic [SEL_W-1:0] r_cur_sel;
    logic [SEL_W-1:0] r_pend_sel;
    logic             r_pend_run;

    logic             w_acc;
    logic             w_term;
    logic             w_tick;
    logic [SEL_W-1:0] w_new_sel;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_m1;

    assign cfg_ready = ena & (r_state != SWITCH);
    assign w_acc     = cfg_valid & cfg_ready;
    assign w_new_sel = SEL_W'(clamp_sel(32'(cfg_sel), CNT_W));
    assign w_m1      = CNT_W'(ratio_m1(32'(r_cur_sel)));
    assign w_term    = (r_state != IDLE) && (w_cnt == w_m1);

    clk_div_counter #(
        .CNT_W (CNT_W),
        .SEL_W (SEL_W)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (ena & (r_state != IDLE)),
        .i_clr     (ena & (r_state == IDLE)),
        .i_sel     (r_cur_sel),
        .o_cnt     (w_cnt),
        .o_tick    (w_tick),
        .o_clk_out (clk_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cur_sel  <= RST_SEL;
            r_pend_sel <= RST_SEL;
            r_pend_run <= 1'b0;
        end else if (ena) begin
            unique case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        r_cur_sel <= w_new_sel;
                        r_state   <= cfg_run ? RUN : IDLE;
                    end
                end
                RUN: begin
                    if (w_acc && w_term) begin
                        r_cur_sel <= w_new_sel;
                        r_state   <= cfg_run ? RUN : IDLE;
                    end else if (w_acc) begin
                        r_pend_sel <= w_new_sel;
                        r_pend_run <= cfg_run;
                        r_state    <= SWITCH;
                    end
                end
                SWITCH: begin
                    // old period must finish before the new ratio lands
                    if (w_term) begin
                        r_cur_sel <= r_pend_sel;
                        r_state   <= r_pend_run ? RUN : IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tick    = w_tick & ena;
    assign busy    = (r_state != IDLE);
    assign cur_sel = r_cur_sel;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: vector table, corner sequences,
// and randomized traffic against a period-level reference model.
module tb_clk_div_ctrl;

    localparam int CW = 8;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_run = 1'b0;
    logic [SW-1:0] cfg_sel = '0;
    logic          cfg_ready;
    logic          tick;
    logic          clk_out;
    logic          busy;
    logic [SW-1:0] cur_sel;

    clk_div_ctrl #(
        .CNT_W       (CW),
        .SEL_W       (SW),
        .DEFAULT_SEL (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_sel   (cfg_sel),
        .cfg_run   (cfg_run),
        .tick      (tick),
        .clk_out   (clk_out),
        .busy      (busy),
        .cur_sel   (cur_sel)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    // reference: mode 0=idle 1=run 2=switch, phase within period
    int m_mode = 0;
    int m_ph   = 0;
    int m_sel  = 0;
    int m_psel = 0;
    bit m_prun = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)",
                     nm, act, exp, cyc_n);
        end
    endtask

    function automatic int m_n();
        return 1 << (m_sel + 1);
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_ph   = 0;
        m_sel  = 0;
        m_psel = 0;
        m_prun = 1'b0;
    endtask

    task automatic check_model();
        chk("busy", 32'(busy), 32'(m_mode != 0));
        chk("cur_sel", 32'(cur_sel), 32'(m_sel));
        chk("tick", 32'(tick),
            32'(ena && m_mode != 0 && m_ph == m_n() - 1));
        chk("clk_out", 32'(clk_out),
            32'(m_mode != 0 && m_ph >= m_n() / 2));
        chk("cfg_ready", 32'(cfg_ready), 32'(ena && m_mode != 2));
    endtask

    task automatic model_step();
        int  csel;
        bit  acc;
        bit  term;
        if (!ena) return;
        csel = (int'(cfg_sel) >= CW) ? CW - 1 : int'(cfg_sel);
        acc  = cfg_valid && (m_mode != 2);
        term = (m_mode != 0) && (m_ph == m_n() - 1);
        if (m_mode == 0) begin
            if (acc) begin
                m_sel  = csel;
                m_mode = cfg_run ? 1 : 0;
                m_ph   = 0;
            end
        end else if (term) begin
            m_ph = 0;
            if (m_mode == 2) begin
                m_sel  = m_psel;
                m_mode = m_prun ? 1 : 0;
            end else if (acc) begin
                m_sel  = csel;
                m_mode = cfg_run ? 1 : 0;
            end
        end else begin
            m_ph = m_ph + 1;
            if (m_mode == 1 && acc) begin
                m_psel = csel;
                m_prun = cfg_run;
                m_mode = 2;
            end
        end
    endtask

    task automatic drive(input bit v, input int s, input bit r, input bit e);
        @(negedge clk);
        cfg_valid = v;
        cfg_sel   = SW'(s);
        cfg_run   = r;
        ena       = e;
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        model_step();
        cyc_n++;
    endtask

    task automatic step(input bit v, input int s, input bit r, input bit e);
        drive(v, s, r, e);
        check_model();
        adv();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cfg_valid = 1'b0;
        ena = 1'b1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_ph(input int ph);
        int k = 0;
        while (!(m_mode != 0 && m_ph == ph) && k < 600) begin
            step(1'b0, 0, 1'b0, 1'b1);
            k++;
        end
        chk("wait_ph", 32'(m_ph), 32'(ph));
    endtask

    task automatic tick_gap(input string nm, input int exp_gap);
        int t1 = -1;
        int t2 = -1;
        for (int k = 0; k < 700 && t2 < 0; k++) begin
            drive(1'b0, 0, 1'b0, 1'b1);
            check_model();
            if (tick === 1'b1) begin
                if (t1 < 0) t1 = cyc_n;
                else t2 = cyc_n;
            end
            adv();
        end
        chk(nm, 32'(t2 - t1), 32'(exp_gap));
    endtask

    typedef struct {
        bit v;
        int s;
        bit r;
        bit busy;
        int sel;
        bit tick;
        bit clko;
        bit rdy;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1, 0,  1, 0, 0, 0, 0, 1};
        tbl[1] = '{0, 0,  0, 1, 0, 0, 0, 1};
        tbl[2] = '{0, 0,  0, 1, 0, 1, 1, 1};
        tbl[3] = '{0, 0,  0, 1, 0, 0, 0, 1};
        tbl[4] = '{0, 0,  0, 1, 0, 1, 1, 1};
        tbl[5] = '{0, 0,  0, 1, 0, 0, 0, 1};
        tbl[6] = '{1, 2,  0, 1, 0, 1, 1, 1};
        tbl[7] = '{0, 0,  0, 0, 2, 0, 0, 1};
        tbl[8] = '{1, 12, 1, 0, 2, 0, 0, 1};
        tbl[9] = '{0, 0,  0, 1, 7, 0, 0, 1};

        rst_n = 1'b0;
        ena   = 1'b1;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_cur_sel", 32'(cur_sel), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        do_reset();

        // sel=0 start, stop on terminal, clamp of an oversized select
        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].s, tbl[i].r, 1'b1);
            chk("tbl_busy", 32'(busy), 32'(tbl[i].busy));
            chk("tbl_cur_sel", 32'(cur_sel), 32'(tbl[i].sel));
            chk("tbl_tick", 32'(tick), 32'(tbl[i].tick));
            chk("tbl_clk_out", 32'(clk_out), 32'(tbl[i].clko));
            chk("tbl_ready", 32'(cfg_ready), 32'(tbl[i].rdy));
            adv();
        end
        tick_gap("t4_gap256", 256);

        // deferred ratio change through SWITCH
        do_reset();
        step(1'b1, 1, 1'b1, 1'b1);
        wait_ph(1);
        step(1'b1, 3, 1'b1, 1'b1);
        chk("t2_switch", 32'(m_mode), 32'd2);
        for (int k = 0; k < 4; k++) step(1'b1, 3, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 0, 1'b0, 1'b1);
        chk("t2_cur_sel", 32'(cur_sel), 32'd3);
        tick_gap("t2_gap16", 16);

        // stop on the terminal cycle goes straight to idle
        do_reset();
        step(1'b1, 2, 1'b1, 1'b1);
        wait_ph(7);
        step(1'b1, 2, 1'b0, 1'b1);
        for (int k = 0; k < 20; k++) step(1'b0, 0, 1'b0, 1'b1);
        chk("t3_busy", 32'(busy), 32'd0);

        // enable drop freezes the count and blocks accepts
        do_reset();
        step(1'b1, 1, 1'b1, 1'b1);
        wait_ph(2);
        for (int k = 0; k < 5; k++) step(1'b1, 5, 1'b1, 1'b0);
        step(1'b0, 0, 1'b0, 1'b1);
        drive(1'b0, 0, 1'b0, 1'b1);
        chk("t5_tick_resume", 32'(tick), 32'd1);
        chk("t5_cur_sel", 32'(cur_sel), 32'd1);
        adv();

        // asynchronous reset while a switch is pending
        do_reset();
        step(1'b1, 1, 1'b1, 1'b1);
        wait_ph(1);
        step(1'b1, 3, 1'b1, 1'b1);
        drive(1'b0, 0, 1'b0, 1'b1);
        chk("t6_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_clk_out", 32'(clk_out), 32'd0);
        chk("t6_tick", 32'(tick), 32'd0);
        chk("t6_cur_sel", 32'(cur_sel), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) step(1'b0, 0, 1'b0, 1'b1);

        // randomized traffic
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 15)),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
